// File: rtl/alu_32bit_behavioral_if.sv
// Operand/result bundle for the registered ALU.
// The master drives operands and select; the slave returns the registered result.
interface alu_32bit_behavioral_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             DL;
    logic             DR;
    logic [3:0]       S;
    logic [WIDTH-1:0] F;
    logic             COUT;

    modport master (
        output A, B, CIN, DL, DR, S,
        input  F, COUT
    );

    modport slave (
        input  A, B, CIN, DL, DR, S,
        output F, COUT
    );
endinterface

// File: rtl/alu_32bit_behavioral.sv
// 32-bit registered ALU: arithmetic, bitwise logic and 1-bit shifts with serial fill.
// The combinational result is captured on every rising clk edge; reset is synchronous.
module alu_32bit_behavioral #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_32bit_behavioral_if.slave   bus
);

    logic [WIDTH-1:0] y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] f_d, f_q;
    logic             cout_d, cout_q;

    // Arithmetic second operand; subtraction relies on ~B plus CIN.
    always_comb begin
        y = '0;
        unique case (bus.S[1:0])
            2'b00: y = '0;
            2'b01: y = bus.B;
            2'b10: y = ~bus.B;
            2'b11: y = '1;
        endcase
    end

    assign sum = {1'b0, bus.A} + {1'b0, y} + {{WIDTH{1'b0}}, bus.CIN};

    always_comb begin
        f_d    = '0;
        cout_d = 1'b0;
        unique case (bus.S[3:2])
            2'b00: begin
                f_d    = sum[WIDTH-1:0];
                cout_d = sum[WIDTH];
            end
            2'b01: begin
                unique case (bus.S[1:0])
                    2'b00: f_d = bus.A & bus.B;
                    2'b01: f_d = bus.A | bus.B;
                    2'b10: f_d = bus.A ^ bus.B;
                    2'b11: f_d = ~bus.A;
                endcase
            end
            2'b10: f_d = {bus.DR, bus.A[WIDTH-1:1]};
            2'b11: f_d = {bus.A[WIDTH-2:0], bus.DL};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            cout_q <= cout_d;
        end
    end

    assign bus.F    = f_q;
    assign bus.COUT = cout_q;

endmodule

// File: tb/tb_alu_32bit_behavioral.sv
// Self-checking bench for alu_32bit_behavioral: directed edge cases plus a random sweep
// against an arithmetic reference model.
module tb_alu_32bit_behavioral;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    alu_32bit_behavioral_if #(.WIDTH(32)) bus ();

    alu_32bit_behavioral #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: {COUT, F} from the operation definitions using 64-bit integer arithmetic.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic dl, input logic dr,
                                          input logic [3:0] s);
        longint unsigned ones = 64'hFFFF_FFFF;
        longint unsigned la   = 64'(a);
        longint unsigned lb   = 64'(b);
        longint unsigned lc   = 64'(cin);
        longint unsigned r;
        case (s)
            4'd0:  r = la + lc;
            4'd1:  r = la + lb + lc;
            4'd2:  r = la + (ones - lb) + lc;
            4'd3:  r = la + ones + lc;
            4'd4:  r = la & lb;
            4'd5:  r = la | lb;
            4'd6:  r = la ^ lb;
            4'd7:  r = ones - la;
            4'd8, 4'd9, 4'd10, 4'd11: r = (la >> 1) | (lc * 0) | (64'(dr) << 31);
            default: r = ((la << 1) & ones) | 64'(dl);
        endcase
        return r[32:0];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic dl, input logic dr, input logic [3:0] s);
        rst_n   = rst;
        bus.A   = a;
        bus.B   = b;
        bus.CIN = cin;
        bus.DL  = dl;
        bus.DR  = dr;
        bus.S   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 4'd1);
            n_vec++;
            if ({bus.COUT, bus.F} !== 33'h0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got COUT=%b F=%h, want COUT=0 F=00000000",
                         i, bus.COUT, bus.F);
            end
        end
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd1);
        n_vec++;
        if ({bus.COUT, bus.F} !== {1'b1, 32'hFFFF_FFFE}) begin
            n_bad++;
            $display("FAIL reset_release: got COUT=%b F=%h, want COUT=1 F=fffffffe",
                     bus.COUT, bus.F);
        end
    endtask

    task automatic test_arith();
        logic [3:0]  ts [6] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
        logic [31:0] ta [6] = '{32'hFFFF_FFFF, 32'd1, 32'd4, 32'd4, 32'd0, 32'd1};
        logic [31:0] tb [6] = '{32'd0, 32'd1, 32'd3, 32'd3, 32'd0, 32'd0};
        logic        tc [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [32:0] te [6] = '{{1'b1, 32'h0}, {1'b0, 32'h3}, {1'b1, 32'h0},
                                {1'b1, 32'h1}, {1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h0}};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i], 1'b0, 1'b0, ts[i]);
            n_vec++;
            if ({bus.COUT, bus.F} !== te[i]) begin
                n_bad++;
                $display("FAIL arith[%0d] S=%0d: got COUT=%b F=%h, want COUT=%b F=%h",
                         i, ts[i], bus.COUT, bus.F, te[i][32], te[i][31:0]);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ts [4] = '{4'd4, 4'd5, 4'd6, 4'd7};
        logic [31:0] ta [4] = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 32'h0};
        logic [31:0] tb [4] = '{32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h5555_5555, 32'hDEAD_BEEF};
        logic [31:0] te [4] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ta[i], tb[i], 1'b1, 1'b1, 1'b1, ts[i]);
            n_vec++;
            if ({bus.COUT, bus.F} !== {1'b0, te[i]}) begin
                n_bad++;
                $display("FAIL logic S=%0d: got COUT=%b F=%h, want COUT=0 F=%h",
                         ts[i], bus.COUT, bus.F, te[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [3:0]  ts [8] = '{4'd8, 4'd8, 4'd12, 4'd12, 4'd11, 4'd11, 4'd15, 4'd15};
        logic        tf [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] te [8] = '{32'h091A_2B3C, 32'h891A_2B3C, 32'h2468_ACF0, 32'h2468_ACF1,
                                32'h091A_2B3C, 32'h891A_2B3C, 32'h2468_ACF0, 32'h2468_ACF1};
        for (int i = 0; i < 8; i++) begin
            // Only the fill bit of the active direction is meaningful; the other is its inverse.
            if (ts[i] < 4'd12)
                drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, ~tf[i], tf[i], ts[i]);
            else
                drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, tf[i], ~tf[i], ts[i]);
            n_vec++;
            if ({bus.COUT, bus.F} !== {1'b0, te[i]}) begin
                n_bad++;
                $display("FAIL shift[%0d] S=%0d fill=%b: got COUT=%b F=%h, want COUT=0 F=%h",
                         i, ts[i], tf[i], bus.COUT, bus.F, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp, held;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            logic        c = 1'($urandom);
            logic        l = 1'($urandom);
            logic        r = 1'($urandom);
            logic [3:0]  s = 4'(i);
            logic        rst = (i != 12);
            exp = rst ? model(a, b, c, l, r, s) : 33'h0;
            drive(rst, a, b, c, l, r, s);
            n_vec++;
            if ({bus.COUT, bus.F} !== exp) begin
                n_bad++;
                $display("FAIL b2b[%0d] rst_n=%b S=%0d: got COUT=%b F=%h, want COUT=%b F=%h",
                         i, rst, s, bus.COUT, bus.F, exp[32], exp[31:0]);
            end
        end
        // Outputs must hold between edges while inputs change.
        held = {bus.COUT, bus.F};
        bus.A = ~bus.A;
        bus.S = bus.S + 4'd5;
        #2;
        n_vec++;
        if ({bus.COUT, bus.F} !== held) begin
            n_bad++;
            $display("FAIL hold: got COUT=%b F=%h, want COUT=%b F=%h",
                     bus.COUT, bus.F, held[32], held[31:0]);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp;
        for (int i = 0; i < 1200; i++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            logic        c = 1'($urandom);
            logic        l = 1'($urandom);
            logic        r = 1'($urandom);
            logic [3:0]  s = 4'($urandom_range(0, 15));
            if (i % 7 == 0) a = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            exp = model(a, b, c, l, r, s);
            drive(1'b1, a, b, c, l, r, s);
            n_vec++;
            if ({bus.COUT, bus.F} !== exp) begin
                n_bad++;
                $display("FAIL random[%0d] S=%0d A=%h B=%h CIN=%b: got COUT=%b F=%h, want COUT=%b F=%h",
                         i, s, a, b, c, bus.COUT, bus.F, exp[32], exp[31:0]);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.A   = '0;
        bus.B   = '0;
        bus.CIN = 1'b0;
        bus.DL  = 1'b0;
        bus.DR  = 1'b0;
        bus.S   = '0;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_32bit_behavioral.md
Name: alu_32bit_behavioral

Overview:
- 32-bit registered ALU: add/increment/subtract/decrement, bitwise logic, and 1-bit left/right shift with a serial fill input.
- Operation is chosen by a 4-bit select S. A combinational result is captured into output registers on each rising clock edge.
- Used as the datapath execution unit. It is also the reference block for the team's ASIC flow.

Parameters:
- WIDTH, 32, datapath width of A, B and F.
  - All behaviour below is stated for WIDTH=32.
  - Constants scale with WIDTH (all-ones = 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in; used by arithmetic ops only.
- DL  input  1  serial fill bit shifted into the LSB on a left shift.
- DR  input  1  serial fill bit shifted into the MSB on a right shift.
- S  input  4  operation select.
- F  output  WIDTH  registered result.
- COUT  output  1  registered carry-out.

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset is synchronous and active-low (rst_n). There are no other clocks and no asynchronous reset.
  - On a rising clk edge with rst_n=0: F<=0 and COUT<=0, regardless of every other input.
  - On a rising clk edge with rst_n=1: F and COUT are loaded with the combinational result of the A, B, CIN, DL, DR and S values present at that edge.
  - Latency is 1 cycle. There is no handshake. A new operation is accepted every cycle.
  - Outputs hold between edges.
  - Asserting reset mid-stream clears the outputs at that edge. The first valid result appears at the first edge where rst_n=1.
- Operation groups are decoded from S[3:2]; S[1:0] selects within the arithmetic and logic groups.
- Arithmetic (S[3:2]=00):
  - Compute the WIDTH+1-bit sum {0,A} + {0,Y} + CIN.
  - Y is selected by S[1:0]: 00 -> 0; 01 -> B; 10 -> ~B; 11 -> all-ones.
  - F = sum[WIDTH-1:0]; COUT = sum[WIDTH], the raw carry. COUT is not inverted into a borrow for subtraction.
  - Resulting operations:
    - S=0: A+CIN (transfer or increment).
    - S=1: A+B+CIN.
    - S=2: A-B-1+CIN. COUT=1 means no borrow.
    - S=3: A-1+CIN (decrement). COUT=1 unless A=0 and CIN=0.
  - Wrap-around is modulo 2^WIDTH; there is no overflow flag.
- Logic (S[3:2]=01), COUT=0:
  - S=4: A&B.
  - S=5: A|B.
  - S=6: A^B.
  - S=7: ~A. B is ignored.
- Shift right (S[3:2]=10, S=8..11): F = {DR, A[WIDTH-1:1]}; COUT=0. A[0] is discarded.
- Shift left (S[3:2]=11, S=12..15): F = {A[WIDTH-2:0], DL}; COUT=0. A[WIDTH-1] is discarded.
- Don't-care inputs:
  - S[1:0] is ignored in both shift groups.
  - CIN is ignored outside the arithmetic group.
  - DL and DR are ignored outside their respective shift group.
- Every one of the 16 S codes is defined. There is no default or X output.
- F and COUT must never be X or Z after a reset has been applied.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with A=FFFFFFFF, S=1 -> F=00000000, COUT=0. Release reset -> the next edge gives F=FFFFFFFE, COUT=1 (with B=FFFFFFFF, CIN=0).
- Arithmetic edges (each checked one cycle after the stimulus edge):
  - S=0, A=FFFFFFFF, CIN=1 -> F=00000000, COUT=1.
  - S=1, A=B=1, CIN=1 -> F=00000003, COUT=0.
  - S=2, A=4, B=3, CIN=0 -> F=00000000, COUT=1.
  - S=2, A=4, B=3, CIN=1 -> F=00000001, COUT=1.
  - S=3, A=0, CIN=0 -> F=FFFFFFFF, COUT=0.
  - S=3, A=1 -> F=00000000, COUT=1.
- Logic, all with COUT=0:
  - A=0F0F0F0F, B=F0F0F0F0: S=4 -> 00000000; S=5 -> FFFFFFFF.
  - A=AAAAAAAA, B=55555555: S=6 -> FFFFFFFF.
  - A=0, B=DEADBEEF: S=7 -> FFFFFFFF.
- Shifts, A=12345678, COUT=0:
  - S=8, DR=0 -> 091A2B3C; S=8, DR=1 -> 891A2B3C.
  - S=12, DL=0 -> 2468ACF0; S=12, DL=1 -> 2468ACF1.
  - S=11 and S=15 give the same results as S=8 and S=12 respectively.
- Back-to-back and mid-stream reset:
  - Change S and operands every cycle. Each output must match the previous cycle's inputs.
  - Drop rst_n for one edge mid-stream -> that cycle's output is 0/0; the stream resumes on the next edge.
- Random sweep: at least 1000 cycles of random A, B, CIN, DL, DR, S, compared against a golden model of the rules above using a 1-cycle delayed compare.
